// File: rtl/maxpool2x2_stage_if.sv
// ============================================================================
// Module   : maxpool2x2_stage_if
// Purpose  : Activation-RAM read/write port bundle used by maxpool2x2_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface maxpool2x2_stage_if;
  logic [15:0] ram_addr_r;
  logic        ram_en_r;
  logic [7:0]  ram_data_r;
  logic [15:0] ram_addr_w;
  logic [7:0]  ram_data_w;
  logic        ram_en;
  logic        ram_wea;

  modport master (
    output ram_addr_r, ram_en_r, ram_addr_w, ram_data_w, ram_en, ram_wea,
    input  ram_data_r
  );

  modport slave (
    input  ram_addr_r, ram_en_r, ram_addr_w, ram_data_w, ram_en, ram_wea,
    output ram_data_r
  );
endinterface

`default_nettype wire

// File: rtl/maxpool2x2_stage.sv
// ============================================================================
// Module   : maxpool2x2_stage
// Purpose  : Signed int8 2x2/stride-2 max-pool, RAM to RAM, 6 cycles/output.
//            Optional clamp to RELU_ZP when MP_RELU_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool2x2_stage #(
  parameter int                 IFMAP_W  = 20,
  parameter int                 IFMAP_H  = 20,
  parameter int                 CHANNELS = 16,
  parameter logic [15:0]        SRC_BASE = 16'h1000,
  parameter logic [15:0]        DST_BASE = 16'h0000,
  parameter logic signed [7:0]  RELU_ZP  = 8'sd0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_mp,
  output logic                    end_mp,
  output logic                    busy,
  maxpool2x2_stage_if.master      ram
);

  localparam logic [15:0] C_COL_LAST = 16'(IFMAP_W / 2 - 1);
  localparam logic [15:0] C_ROW_LAST = 16'(IFMAP_H / 2 - 1);
  localparam logic [15:0] C_CH_LAST  = 16'(CHANNELS - 1);
  localparam logic [15:0] C_ROW_STEP = 16'(IFMAP_W);
  localparam logic [15:0] C_ROW_SKIP = 16'(IFMAP_W + 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_RD3  = 3'd4,
    S_LAST = 3'd5,
    S_WR   = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [15:0]        r_src;
  logic [15:0]        r_dst;
  logic [15:0]        r_col;
  logic [15:0]        r_row;
  logic [15:0]        r_ch;
  logic signed [7:0]  r_max;
  logic signed [7:0]  w_din;
  logic signed [7:0]  w_wr_data;
  logic               w_last_col;
  logic               w_last_row;
  logic               w_last_out;

  assign w_din      = ram.ram_data_r;
  assign w_last_col = (r_col == C_COL_LAST);
  assign w_last_row = (r_row == C_ROW_LAST);
  assign w_last_out = w_last_col && w_last_row && (r_ch == C_CH_LAST);

`ifdef MP_RELU_EN
  assign w_wr_data = (r_max < RELU_ZP) ? RELU_ZP : r_max;
`else
  assign w_wr_data = r_max;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // r_src points at the top-left pixel of the current window.
  always_comb begin
    w_next          = r_state;
    end_mp          = 1'b0;
    busy            = 1'b0;
    ram.ram_en_r    = 1'b0;
    ram.ram_addr_r  = 16'd0;
    ram.ram_en      = 1'b0;
    ram.ram_wea     = 1'b0;
    ram.ram_addr_w  = 16'd0;
    ram.ram_data_w  = 8'd0;
    case (r_state)
      S_IDLE: begin
        if (start_mp) w_next = S_RD0;
      end
      S_RD0: begin
        busy           = 1'b1;
        ram.ram_en_r   = 1'b1;
        ram.ram_addr_r = r_src;
        w_next         = S_RD1;
      end
      S_RD1: begin
        busy           = 1'b1;
        ram.ram_en_r   = 1'b1;
        ram.ram_addr_r = r_src + 16'd1;
        w_next         = S_RD2;
      end
      S_RD2: begin
        busy           = 1'b1;
        ram.ram_en_r   = 1'b1;
        ram.ram_addr_r = r_src + C_ROW_STEP;
        w_next         = S_RD3;
      end
      S_RD3: begin
        busy           = 1'b1;
        ram.ram_en_r   = 1'b1;
        ram.ram_addr_r = r_src + C_ROW_STEP + 16'd1;
        w_next         = S_LAST;
      end
      S_LAST: begin
        busy   = 1'b1;
        w_next = S_WR;
      end
      S_WR: begin
        busy           = 1'b1;
        ram.ram_en     = 1'b1;
        ram.ram_wea    = 1'b1;
        ram.ram_addr_w = r_dst;
        ram.ram_data_w = w_wr_data;
        w_next         = w_last_out ? S_DONE : S_RD0;
      end
      S_DONE: begin
        end_mp = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Channels are contiguous, so skipping the odd row also lands on the next channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src <= 16'd0;
      r_dst <= 16'd0;
      r_col <= 16'd0;
      r_row <= 16'd0;
      r_ch  <= 16'd0;
      r_max <= 8'sd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_mp) begin
            r_src <= SRC_BASE;
            r_dst <= DST_BASE;
            r_col <= 16'd0;
            r_row <= 16'd0;
            r_ch  <= 16'd0;
          end
        end
        S_RD1: r_max <= w_din;
        S_RD2, S_RD3, S_LAST: begin
          if (w_din > r_max) r_max <= w_din;
        end
        S_WR: begin
          r_dst <= r_dst + 16'd1;
          if (w_last_col) begin
            r_col <= 16'd0;
            r_src <= r_src + C_ROW_SKIP;
            if (w_last_row) begin
              r_row <= 16'd0;
              r_ch  <= r_ch + 16'd1;
            end else begin
              r_row <= r_row + 16'd1;
            end
          end else begin
            r_col <= r_col + 16'd1;
            r_src <= r_src + 16'd2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
